// File: rtl/qk_ctrl_pkg.sv
// Shared definitions for the attention-core sequencer: FSM states, the
// 17-bit instruction bit map and the decoded instruction field bundle.
package qk_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LDQ   = 3'd1,
      ST_LDK   = 3'd2,
      ST_KLOAD = 3'd3,
      ST_KGAP  = 3'd4,
      ST_EXEC  = 3'd5,
      ST_DRAIN = 3'd6,
      ST_DONE  = 3'd7
   } state_e;

   localparam int INST_W = 17;

   localparam int INST_OFIFO_RD = 16;
   localparam int INST_QK_LSB   = 12;
   localparam int INST_PS_LSB   = 8;
   localparam int INST_EXEC     = 7;
   localparam int INST_KLOAD    = 6;
   localparam int INST_Q_RD     = 5;
   localparam int INST_Q_WR     = 4;
   localparam int INST_K_RD     = 3;
   localparam int INST_K_WR     = 2;
   localparam int INST_P_RD     = 1;
   localparam int INST_P_WR     = 0;

   localparam int QK_ADDR_W = 4;
   localparam int PS_ADDR_W = 4;

   typedef struct packed {
      logic                 ofifoRd;
      logic [QK_ADDR_W-1:0] qkAddr;
      logic [PS_ADDR_W-1:0] psAddr;
      logic                 exec;
      logic                 kload;
      logic                 qRd;
      logic                 qWr;
      logic                 kRd;
      logic                 kWr;
      logic                 pRd;
      logic                 pWr;
   } inst_fields_t;

endpackage

// File: rtl/qk_inst_pack.sv
// Packs decoded opcode flags and addresses into the 17-bit core instruction
// word; purely combinational.
module qk_inst_pack
   import qk_ctrl_pkg::*;
(
   input  inst_fields_t      fields_i,
   output logic [INST_W-1:0] inst_o
);

   // Every bit position comes from the package map so the layout lives in one place.
   always_comb begin
      inst_o                                = '0;
      inst_o[INST_OFIFO_RD]                 = fields_i.ofifoRd;
      inst_o[INST_QK_LSB +: QK_ADDR_W]      = fields_i.qkAddr;
      inst_o[INST_PS_LSB +: PS_ADDR_W]      = fields_i.psAddr;
      inst_o[INST_EXEC]                     = fields_i.exec;
      inst_o[INST_KLOAD]                    = fields_i.kload;
      inst_o[INST_Q_RD]                     = fields_i.qRd;
      inst_o[INST_Q_WR]                     = fields_i.qWr;
      inst_o[INST_K_RD]                     = fields_i.kRd;
      inst_o[INST_K_WR]                     = fields_i.kWr;
      inst_o[INST_P_RD]                     = fields_i.pRd;
      inst_o[INST_P_WR]                     = fields_i.pWr;
   end

endmodule

// File: rtl/qk_core_ctrl.sv
// Job sequencer for one attention core: loads Q and K from the host, runs the
// kernel load and execute passes, then drains the output FIFO into psum memory.
module qk_core_ctrl
   import qk_ctrl_pkg::*;
#(
   parameter int COL      = 8,
   parameter int AW       = 4,
   parameter int KGAP     = 1,
   parameter int FIFO_LAT = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [AW-1:0]     nq_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic              ofifo_valid_i,
   output logic [INST_W-1:0] inst_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int GW = (KGAP > 1) ? $clog2(KGAP) : 1;

   state_e               state_q, state_d;
   logic [AW-1:0]        nq_q, nq_d;
   logic [AW-1:0]        cnt_q, cnt_d;
   logic [AW-1:0]        drainCnt_q, drainCnt_d;
   logic [GW-1:0]        gapCnt_q, gapCnt_d;
   logic [FIFO_LAT-1:0]  pend_q, pend_d;
   logic                 inReady_q, inReady_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [INST_W-1:0]    inst_q, instWord;
   inst_fields_t         fields;
   logic                 xfer;

   assign xfer = in_valid_i && inReady_q;

   // Next-state logic; fields describes the instruction shown on the bus next
   // cycle. pend is a one-hot delay line marking the single row in flight
   // between ofifo_rd and the matching psum write.
   always_comb begin
      state_d    = state_q;
      nq_d       = nq_q;
      cnt_d      = cnt_q;
      drainCnt_d = drainCnt_q;
      gapCnt_d   = gapCnt_q;
      pend_d     = pend_q << 1;
      inReady_d  = inReady_q;
      done_d     = 1'b0;
      fields     = '0;

      case (state_q)
         ST_IDLE: begin
            inReady_d = 1'b0;
            if (start_i) begin
               nq_d       = nq_i;
               cnt_d      = '0;
               drainCnt_d = '0;
               gapCnt_d   = '0;
               pend_d     = '0;
               inReady_d  = 1'b1;
               state_d    = ST_LDQ;
            end
         end

         ST_LDQ: begin
            if (xfer) begin
               fields.qWr    = 1'b1;
               fields.qkAddr = QK_ADDR_W'(cnt_q);
               if (cnt_q == nq_q) begin
                  cnt_d   = '0;
                  state_d = ST_LDK;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
         end

         ST_LDK: begin
            if (xfer) begin
               fields.kWr    = 1'b1;
               fields.qkAddr = QK_ADDR_W'(cnt_q);
               if (cnt_q == AW'(COL - 1)) begin
                  cnt_d     = '0;
                  inReady_d = 1'b0;
                  state_d   = ST_KLOAD;
               end else begin
                  cnt_d = cnt_q + AW'(1);
               end
            end
         end

         ST_KLOAD: begin
            fields.kRd    = 1'b1;
            fields.kload  = 1'b1;
            fields.qkAddr = QK_ADDR_W'(cnt_q);
            if (cnt_q == AW'(COL - 1)) begin
               cnt_d   = '0;
               state_d = (KGAP == 0) ? ST_EXEC : ST_KGAP;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end

         ST_KGAP: begin
            if (gapCnt_q == GW'(KGAP - 1)) begin
               gapCnt_d = '0;
               state_d  = ST_EXEC;
            end else begin
               gapCnt_d = gapCnt_q + GW'(1);
            end
         end

         ST_EXEC: begin
            fields.qRd    = 1'b1;
            fields.exec   = 1'b1;
            fields.qkAddr = QK_ADDR_W'(cnt_q);
            if (cnt_q == nq_q) begin
               cnt_d   = '0;
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end

         ST_DRAIN: begin
            if (pend_q[FIFO_LAT-1]) begin
               fields.pWr    = 1'b1;
               fields.psAddr = PS_ADDR_W'(drainCnt_q);
               drainCnt_d    = drainCnt_q + AW'(1);
               if (drainCnt_q == nq_q) begin
                  state_d = ST_DONE;
               end
            end else if ((pend_q == '0) && ofifo_valid_i) begin
               fields.ofifoRd = 1'b1;
               pend_d[0]      = 1'b1;
            end
         end

         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);
   end

   qk_inst_pack u_pack (
      .fields_i (fields),
      .inst_o   (instWord)
   );

   // All state and every output are registered and cleared asynchronously.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         nq_q       <= '0;
         cnt_q      <= '0;
         drainCnt_q <= '0;
         gapCnt_q   <= '0;
         pend_q     <= '0;
         inReady_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         inst_q     <= '0;
      end else begin
         state_q    <= state_d;
         nq_q       <= nq_d;
         cnt_q      <= cnt_d;
         drainCnt_q <= drainCnt_d;
         gapCnt_q   <= gapCnt_d;
         pend_q     <= pend_d;
         inReady_q  <= inReady_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         inst_q     <= instWord;
      end
   end

   assign in_ready_o = inReady_q;
   assign inst_o     = inst_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;

endmodule

// File: tb/tb_qk_core_ctrl.sv
// Self-checking bench for qk_core_ctrl: directed jobs plus randomized handshakes,
// compared each cycle against a phase-level model of the expected instruction stream.
module tb_qk_core_ctrl;

   localparam int COL      = 8;
   localparam int AW       = 4;
   localparam int KGAP     = 1;
   localparam int FIFO_LAT = 1;

   localparam int P_IDLE  = 0;
   localparam int P_LOAD  = 1;
   localparam int P_PLAY  = 2;
   localparam int P_DRAIN = 3;
   localparam int P_DONE  = 4;

   localparam int F_QWR = 1 << 4;
   localparam int F_KWR = 1 << 2;
   localparam int F_KRD = (1 << 3) | (1 << 6);
   localparam int F_QRD = (1 << 5) | (1 << 7);
   localparam int F_PWR = 1;
   localparam int F_ORD = 1 << 16;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] nq = '0;
   logic          inValid = 1'b0;
   logic          ofifoValid = 1'b0;
   logic          inReady;
   logic [16:0]   inst;
   logic          busy;
   logic          done;

   int compared = 0;
   int mismatched = 0;

   int phase = P_IDLE;
   int jobNq = 0;
   int xfers = 0;
   int stalls = 0;
   int rdAge = -1;
   int writes = 0;
   int playQ[$];
   logic [16:0] expInst = '0;
   logic        expReady = 1'b0;
   logic        expBusy = 1'b0;
   logic        expDone = 1'b0;

   qk_core_ctrl #(.COL(COL), .AW(AW), .KGAP(KGAP), .FIFO_LAT(FIFO_LAT)) dut (
      .clk_i         (clock),
      .reset_i       (reset),
      .start_i       (start),
      .nq_i          (nq),
      .in_valid_i    (inValid),
      .in_ready_o    (inReady),
      .ofifo_valid_i (ofifoValid),
      .inst_o        (inst),
      .busy_o        (busy),
      .done_o        (done)
   );

   always #5 clock = ~clock;

   function automatic logic [16:0] word(input int flags, input int qk, input int ps);
      int w;
      w = flags | (qk << 12) | (ps << 8);
      return w[16:0];
   endfunction

   task automatic checkOutput(input string tag, input logic [16:0] obs, input logic [16:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   task automatic checkCount(input string tag, input int obs, input int exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: predicts the outputs after the coming clock edge from the
   // job phase, transfer count, a scripted playback queue and the in-flight read age.
   task automatic modelStep(input logic st, input logic [AW-1:0] nqIn, input logic iv, input logic ov);
      logic [16:0] ni;
      logic        nr, nb, nd;
      ni = '0; nr = 1'b0; nb = 1'b0; nd = 1'b0;
      case (phase)
         P_IDLE: begin
            if (st) begin
               jobNq = int'(nqIn);
               xfers = 0;
               stalls = 0;
               nr = 1'b1;
               nb = 1'b1;
               phase = P_LOAD;
            end
         end
         P_LOAD: begin
            nb = 1'b1;
            if (expReady && iv) begin
               ni = (xfers <= jobNq) ? word(F_QWR, xfers, 0) : word(F_KWR, xfers - jobNq - 1, 0);
               xfers++;
            end else if (expReady) begin
               stalls++;
            end
            if (xfers == jobNq + 1 + COL) begin
               playQ.delete();
               for (int i = 0; i < COL; i++) playQ.push_back(int'(word(F_KRD, i, 0)));
               for (int i = 0; i < KGAP; i++) playQ.push_back(0);
               for (int i = 0; i <= jobNq; i++) playQ.push_back(int'(word(F_QRD, i, 0)));
               phase = P_PLAY;
            end else begin
               nr = 1'b1;
            end
         end
         P_PLAY: begin
            nb = 1'b1;
            ni = 17'(playQ.pop_front());
            if (playQ.size() == 0) begin
               phase = P_DRAIN;
               rdAge = -1;
               writes = 0;
            end
         end
         P_DRAIN: begin
            nb = 1'b1;
            if (rdAge >= 0) begin
               rdAge++;
               if (rdAge == FIFO_LAT) begin
                  ni = word(F_PWR, 0, writes);
                  writes++;
                  rdAge = -1;
                  if (writes == jobNq + 1) phase = P_DONE;
               end
            end else if (ov) begin
               ni = word(F_ORD, 0, 0);
               rdAge = 0;
            end
         end
         default: begin
            nd = 1'b1;
            nb = 1'b1;
            phase = P_IDLE;
         end
      endcase
      expInst = ni;
      expReady = nr;
      expBusy = nb;
      expDone = nd;
   endtask

   // One clock cycle: check outputs at the falling edge, then drive the next inputs.
   task automatic applyStimulus(input logic st, input logic [AW-1:0] nqIn, input logic iv, input logic ov);
      @(negedge clock);
      checkOutput("inst", inst, expInst);
      checkOutput("in_ready", 17'(inReady), 17'(expReady));
      checkOutput("busy", 17'(busy), 17'(expBusy));
      checkOutput("done", 17'(done), 17'(expDone));
      start = st;
      nq = nqIn;
      inValid = iv;
      ofifoValid = ov;
      modelStep(st, nqIn, iv, ov);
   endtask

   task automatic runJob(input int nqv, input int ivMode, input int ovMode, input bit midStart,
                         input bit abortAtQ2, output int cycles, output int pwrs, output int dones,
                         output int maxQ, output bit aborted);
      int  n;
      int  drainSteps;
      bit  finished;
      logic iv, ov, st;
      n = 0; drainSteps = 0; finished = 1'b0;
      cycles = 0; pwrs = 0; dones = 0; maxQ = -1; aborted = 1'b0;
      applyStimulus(1'b1, AW'(nqv), 1'b0, 1'b0);
      n = 1;
      while (!finished && n < 1500) begin
         case (ivMode)
            0: iv = 1'b1;
            1: iv = (n % 2 == 1);
            default: iv = ($urandom_range(0, 3) != 0);
         endcase
         if (phase == P_DRAIN) drainSteps++;
         case (ovMode)
            0: ov = 1'b1;
            1: ov = (drainSteps > 5) && (drainSteps % 3 != 0);
            default: ov = ($urandom_range(0, 1) == 1);
         endcase
         st = midStart && (n == 20);
         applyStimulus(st, AW'($urandom_range(0, 15)), iv, ov);
         n++;
         if (inst[0]) pwrs++;
         if (inst[5] && int'(inst[15:12]) > maxQ) maxQ = int'(inst[15:12]);
         if (abortAtQ2 && inst == word(F_QRD, 2, 0)) begin
            aborted = 1'b1;
            return;
         end
         if (done) begin
            dones++;
            finished = 1'b1;
            cycles = n;
         end
      end
      compared++;
      assert (finished) else begin
         mismatched++;
         $error("[TB] FAIL job_timeout: observed no done after %0d cycles, expected done", n);
      end
      for (int k = 0; k < 2; k++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0);
         if (done) dones++;
      end
   endtask

   initial begin
      int c2, c3, stalls3, pw, dn, mq;
      bit ab;

      // Reset held three cycles, then released between clock edges.
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      #1 reset = 1'b0;
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);

      $display("[TB] job nq=3, continuous valid");
      runJob(3, 0, 0, 1'b0, 1'b0, c2, pw, dn, mq, ab);
      checkCount("job2_pwr_count", pw, 4);
      checkCount("job2_done_count", dn, 1);
      checkCount("job2_max_qaddr", mq, 3);

      $display("[TB] job nq=3, toggling valid");
      runJob(3, 1, 0, 1'b0, 1'b0, c3, pw, dn, mq, ab);
      stalls3 = stalls;
      checkCount("stall_growth", c3 - c2, stalls3);
      checkCount("job3_pwr_count", pw, 4);

      $display("[TB] job nq=3, late intermittent ofifo_valid");
      runJob(3, 0, 1, 1'b0, 1'b0, c3, pw, dn, mq, ab);
      checkCount("job4_pwr_count", pw, 4);
      checkCount("job4_done_count", dn, 1);

      $display("[TB] job nq=15 with start pulsed mid-job");
      runJob(15, 0, 2, 1'b1, 1'b0, c3, pw, dn, mq, ab);
      checkCount("job5_max_qaddr", mq, 15);
      checkCount("job5_pwr_count", pw, 16);
      checkCount("job5_done_count", dn, 1);

      for (int j = 0; j < 4; j++) begin
         int nqr;
         nqr = $urandom_range(0, 15);
         $display("[TB] random job nq=%0d", nqr);
         runJob(nqr, 2, 2, 1'b0, 1'b0, c3, pw, dn, mq, ab);
         checkCount("rand_pwr_count", pw, nqr + 1);
         checkCount("rand_done_count", dn, 1);
      end

      $display("[TB] reset during execute");
      runJob(5, 0, 0, 1'b0, 1'b1, c3, pw, dn, mq, ab);
      checkCount("abort_reached_q2", int'(ab), 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort_inst", inst, '0);
      checkOutput("abort_busy", 17'(busy), '0);
      checkOutput("abort_in_ready", 17'(inReady), '0);
      checkOutput("abort_done", 17'(done), '0);
      phase = P_IDLE;
      playQ.delete();
      expInst = '0; expReady = 1'b0; expBusy = 1'b0; expDone = 1'b0;
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      #1 reset = 1'b0;
      runJob(0, 0, 0, 1'b0, 1'b0, c3, pw, dn, mq, ab);
      checkCount("post_abort_pwr_count", pw, 1);
      checkCount("post_abort_done_count", dn, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
